// File: rtl/mips_cpu_boot.sv
// Flash boot loader: copies BOOT_WORDS big-endian words from parallel flash into main memory.
// Optional image checksum enabled by defining BOOT_CHECKSUM_EN.
module mips_cpu_boot #(
    parameter int unsigned FLASH_WAIT = 4,
    parameter int unsigned BOOT_WORDS = 32768,
    parameter int unsigned FLASH_BASE = 0
) (
    input  logic        CLOCK_50,
    input  logic        Global_Reset,
    output logic [21:0] FL_ADDR,
    input  logic [7:0]  FL_DQ,
    output logic        FL_CE_N,
    output logic        FL_OE_N,
    output logic        FL_WE_N,
    output logic        FL_RST_N,
    output logic        mem_wr_req,
    output logic [19:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_ack,
    output logic [19:0] boot_count,
    output logic        boot_done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {WAKE, READ, WRITE, DONE} state_t;

    localparam logic [3:0]  WAIT_M1 = 4'(FLASH_WAIT - 1);
    localparam logic [20:0] LAST_W  = 21'(BOOT_WORDS);
    localparam logic [21:0] BASE    = 22'(FLASH_BASE);

    state_t      state;
    logic [3:0]  cnt;
    logic [19:0] w;
    logic [1:0]  b;
    logic [23:0] asm_word;
    logic [20:0] w_next;
    logic        xfer;

    assign FL_WE_N = 1'b1;
    assign w_next  = {1'b0, w} + 21'd1;
    // req is only ever high in WRITE, so an ack outside WRITE is ignored.
    assign xfer    = (state == WRITE) && mem_wr_ack;

    always_ff @(posedge CLOCK_50 or posedge Global_Reset) begin
        if (Global_Reset) begin
            state       <= WAKE;
            cnt         <= '0;
            w           <= '0;
            b           <= '0;
            asm_word    <= '0;
            FL_ADDR     <= '0;
            FL_CE_N     <= 1'b1;
            FL_OE_N     <= 1'b1;
            FL_RST_N    <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            boot_count  <= '0;
            boot_done   <= 1'b0;
        end else begin
            FL_RST_N <= 1'b1;
            case (state)
                WAKE: begin
                    if (cnt == WAIT_M1) begin
                        cnt     <= '0;
                        w       <= '0;
                        b       <= '0;
                        FL_ADDR <= BASE;
                        FL_CE_N <= 1'b0;
                        FL_OE_N <= 1'b0;
                        state   <= READ;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                READ: begin
                    if (cnt == WAIT_M1) begin
                        cnt      <= '0;
                        asm_word <= {asm_word[15:0], FL_DQ};
                        if (b == 2'd3) begin
                            mem_wr_req  <= 1'b1;
                            mem_wr_addr <= w;
                            mem_wr_data <= {asm_word, FL_DQ};
                            state       <= WRITE;
                        end else begin
                            b       <= b + 2'd1;
                            FL_ADDR <= BASE + {w, b + 2'd1};
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    if (xfer) begin
                        mem_wr_req <= 1'b0;
                        boot_count <= w_next[19:0];
                        if (w_next == LAST_W) begin
                            FL_CE_N   <= 1'b1;
                            FL_OE_N   <= 1'b1;
                            FL_ADDR   <= '0;
                            boot_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            w       <= w_next[19:0];
                            b       <= '0;
                            FL_ADDR <= BASE + {w_next[19:0], 2'b00};
                            state   <= READ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge CLOCK_50 or posedge Global_Reset) begin
        if (Global_Reset)
            checksum <= '0;
        else if (xfer)
            checksum <= checksum + mem_wr_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mips_cpu_boot.sv
// Directed bench for mips_cpu_boot: three instances cover basic copy/stall/reset,
// a non-zero flash base, and the single-cycle flash wait.
module tb_mips_cpu_boot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned we_bad = 0;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [31:0] SUM_A = 32'h63DAFFF1;
    localparam logic [31:0] SUM_B = 32'h11223344;
    localparam logic [31:0] SUM_C = 32'hA6B8CADB;
`else
    localparam logic [31:0] SUM_A = 32'h0;
    localparam logic [31:0] SUM_B = 32'h0;
    localparam logic [31:0] SUM_C = 32'h0;
`endif

    // Instance A: FLASH_WAIT=4, BOOT_WORDS=2, FLASH_BASE=0
    logic        rst_a = 1'b1, ack_a = 1'b1, ce_a, oe_a, we_a, frst_a, req_a, done_a;
    logic [21:0] addr_a;
    logic [7:0]  dq_a;
    logic [19:0] waddr_a, cnt_a;
    logic [31:0] wdata_a, sum_a;
    logic [7:0]  flash_a [8];
    logic [19:0] qa_addr [$];
    logic [31:0] qa_data [$];

    // Instance B: FLASH_WAIT=4, BOOT_WORDS=1, FLASH_BASE=0x100
    logic        rst_b = 1'b1, ack_b = 1'b1, ce_b, oe_b, we_b, frst_b, req_b, done_b;
    logic [21:0] addr_b;
    logic [7:0]  dq_b;
    logic [19:0] waddr_b, cnt_b;
    logic [31:0] wdata_b, sum_b;
    logic [7:0]  flash_b [4];
    logic [19:0] qb_addr [$];
    logic [31:0] qb_data [$];

    // Instance C: FLASH_WAIT=1, BOOT_WORDS=3, FLASH_BASE=0
    logic        rst_c = 1'b1, ack_c = 1'b1, ce_c, oe_c, we_c, frst_c, req_c, done_c;
    logic [21:0] addr_c;
    logic [7:0]  dq_c;
    logic [19:0] waddr_c, cnt_c;
    logic [31:0] wdata_c, sum_c;
    logic [7:0]  flash_c [16];
    logic [19:0] qc_addr [$];
    logic [31:0] qc_data [$];

    assign dq_a = flash_a[addr_a[2:0]];
    assign dq_b = flash_b[addr_b[1:0]];
    assign dq_c = flash_c[addr_c[3:0]];

    mips_cpu_boot #(.FLASH_WAIT(4), .BOOT_WORDS(2), .FLASH_BASE(0)) u_a (
        .CLOCK_50(clk), .Global_Reset(rst_a), .FL_ADDR(addr_a), .FL_DQ(dq_a),
        .FL_CE_N(ce_a), .FL_OE_N(oe_a), .FL_WE_N(we_a), .FL_RST_N(frst_a),
        .mem_wr_req(req_a), .mem_wr_addr(waddr_a), .mem_wr_data(wdata_a),
        .mem_wr_ack(ack_a), .boot_count(cnt_a), .boot_done(done_a), .checksum(sum_a));

    mips_cpu_boot #(.FLASH_WAIT(4), .BOOT_WORDS(1), .FLASH_BASE(32'h100)) u_b (
        .CLOCK_50(clk), .Global_Reset(rst_b), .FL_ADDR(addr_b), .FL_DQ(dq_b),
        .FL_CE_N(ce_b), .FL_OE_N(oe_b), .FL_WE_N(we_b), .FL_RST_N(frst_b),
        .mem_wr_req(req_b), .mem_wr_addr(waddr_b), .mem_wr_data(wdata_b),
        .mem_wr_ack(ack_b), .boot_count(cnt_b), .boot_done(done_b), .checksum(sum_b));

    mips_cpu_boot #(.FLASH_WAIT(1), .BOOT_WORDS(3), .FLASH_BASE(0)) u_c (
        .CLOCK_50(clk), .Global_Reset(rst_c), .FL_ADDR(addr_c), .FL_DQ(dq_c),
        .FL_CE_N(ce_c), .FL_OE_N(oe_c), .FL_WE_N(we_c), .FL_RST_N(frst_c),
        .mem_wr_req(req_c), .mem_wr_addr(waddr_c), .mem_wr_data(wdata_c),
        .mem_wr_ack(ack_c), .boot_count(cnt_c), .boot_done(done_c), .checksum(sum_c));

    always @(posedge clk) begin
        if (req_a === 1'b1 && ack_a === 1'b1) begin qa_addr.push_back(waddr_a); qa_data.push_back(wdata_a); end
        if (req_b === 1'b1 && ack_b === 1'b1) begin qb_addr.push_back(waddr_b); qb_data.push_back(wdata_b); end
        if (req_c === 1'b1 && ack_c === 1'b1) begin qc_addr.push_back(waddr_c); qc_data.push_back(wdata_c); end
    end

    always @(negedge clk)
        if (we_a !== 1'b1 || we_b !== 1'b1 || we_c !== 1'b1) we_bad++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req_a(output int n);
        n = 0;
        while (req_a !== 1'b1 && n < 200) begin tick(); n++; end
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin tick(); n++; end
    endtask

    task automatic clear_a();
        qa_addr.delete();
        qa_data.delete();
    endtask

    initial begin
        int n;
        logic stable;

        flash_a[0] = 8'h3C; flash_a[1] = 8'h1D; flash_a[2] = 8'h00; flash_a[3] = 8'h01;
        flash_a[4] = 8'h27; flash_a[5] = 8'hBD; flash_a[6] = 8'hFF; flash_a[7] = 8'hF0;
        flash_b[0] = 8'h11; flash_b[1] = 8'h22; flash_b[2] = 8'h33; flash_b[3] = 8'h44;
        flash_c[0] = 8'h01; flash_c[1] = 8'h02; flash_c[2]  = 8'h03; flash_c[3]  = 8'h04;
        flash_c[4] = 8'hA5; flash_c[5] = 8'hB6; flash_c[6]  = 8'hC7; flash_c[7]  = 8'hD8;
        flash_c[8] = 8'hFF; flash_c[9] = 8'hFF; flash_c[10] = 8'hFF; flash_c[11] = 8'hFF;
        for (int unsigned i = 12; i < 16; i++) flash_c[i] = 8'h00;

        // Reset values
        repeat (3) tick();
        check_eq("rst_fl_addr", addr_a, 0);
        check_eq("rst_ce_n", ce_a, 1);
        check_eq("rst_oe_n", oe_a, 1);
        check_eq("rst_we_n", we_a, 1);
        check_eq("rst_fl_rst_n", frst_a, 0);
        check_eq("rst_req", req_a, 0);
        check_eq("rst_waddr", waddr_a, 0);
        check_eq("rst_wdata", wdata_a, 0);
        check_eq("rst_count", cnt_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_sum", sum_a, 0);

        // Basic copy, ack tied high
        rst_a = 1'b0;
        n = 0;
        while (req_a !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (n == 1) check_eq("wake_fl_rst_n", frst_a, 1);
        end
        check_eq("first_req_latency", n, 20);
        check_eq("first_req_addr", waddr_a, 0);
        check_eq("first_req_data", wdata_a, 32'h3C1D0001);
        wait_done_a(n);
        check_eq("done_latency", n, 18);
        check_eq("basic_nwrites", qa_addr.size(), 2);
        check_eq("basic_w0_addr", qa_addr[0], 0);
        check_eq("basic_w0_data", qa_data[0], 32'h3C1D0001);
        check_eq("basic_w1_addr", qa_addr[1], 1);
        check_eq("basic_w1_data", qa_data[1], 32'h27BDFFF0);
        check_eq("basic_count", cnt_a, 2);
        check_eq("basic_sum", sum_a, SUM_A);
        check_eq("done_ce_n", ce_a, 1);
        check_eq("done_oe_n", oe_a, 1);
        check_eq("done_fl_addr", addr_a, 0);
        check_eq("done_req", req_a, 0);

        // In DONE an ack pulse must not produce a write
        ack_a = 1'b0; tick();
        ack_a = 1'b1; tick();
        ack_a = 1'b0; tick();
        check_eq("done_ack_nwrites", qa_addr.size(), 2);
        check_eq("done_ack_count", cnt_a, 2);
        check_eq("done_ack_done", done_a, 1);

        // Ack stall during the first WRITE
        rst_a = 1'b1; clear_a(); tick(); tick();
        rst_a = 1'b0;
        wait_req_a(n);
        check_eq("stall_req_latency", n, 20);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (req_a !== 1'b1 || waddr_a !== 20'd0 || wdata_a !== 32'h3C1D0001 || addr_a !== 22'h3)
                stable = 1'b0;
        end
        check_eq("stall_stable", stable, 1);
        check_eq("stall_nwrites", qa_addr.size(), 0);
        ack_a = 1'b1; tick();
        check_eq("stall_release_nwrites", qa_addr.size(), 1);
        check_eq("stall_release_count", cnt_a, 1);
        check_eq("stall_release_req", req_a, 0);
        wait_done_a(n);
        check_eq("stall_done", done_a, 1);
        check_eq("stall_nwrites_final", qa_addr.size(), 2);
        check_eq("stall_w1_data", qa_data[1], 32'h27BDFFF0);

        // Reset during the second word's READ
        rst_a = 1'b1; clear_a(); tick();
        rst_a = 1'b0;
        wait_req_a(n);
        repeat (6) tick();
        check_eq("mid_in_read_w1", addr_a, 22'h5);
        check_eq("mid_count_before", cnt_a, 1);
        rst_a = 1'b1;
        #1;
        check_eq("mid_rst_fl_addr", addr_a, 0);
        check_eq("mid_rst_ce_n", ce_a, 1);
        check_eq("mid_rst_oe_n", oe_a, 1);
        check_eq("mid_rst_fl_rst_n", frst_a, 0);
        check_eq("mid_rst_req", req_a, 0);
        check_eq("mid_rst_count", cnt_a, 0);
        check_eq("mid_rst_waddr", waddr_a, 0);
        check_eq("mid_rst_wdata", wdata_a, 0);
        check_eq("mid_rst_sum", sum_a, 0);
        clear_a(); tick();
        rst_a = 1'b0;
        wait_done_a(n);
        check_eq("mid_nwrites", qa_addr.size(), 2);
        check_eq("mid_first_addr", qa_addr[0], 0);
        check_eq("mid_first_data", qa_data[0], 32'h3C1D0001);
        check_eq("mid_sum", sum_a, SUM_A);

        // Address sequence with a non-zero flash base
        rst_b = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick();
            check_eq($sformatf("seq_addr_%0d", i), addr_b, (i < 4) ? 22'h0 : 22'(32'h100 + (i - 4) / 4));
        end
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin tick(); n++; end
        check_eq("seq_done", done_b, 1);
        check_eq("seq_nwrites", qb_addr.size(), 1);
        check_eq("seq_w0_addr", qb_addr[0], 0);
        check_eq("seq_w0_data", qb_data[0], 32'h11223344);
        check_eq("seq_count", cnt_b, 1);
        check_eq("seq_sum", sum_b, SUM_B);

        // FLASH_WAIT=1, three words with ack high
        rst_c = 1'b0;
        n = 0;
        while (done_c !== 1'b1 && n < 200) begin tick(); n++; end
        check_eq("fast_done_latency", n, 16);
        check_eq("fast_nwrites", qc_addr.size(), 3);
        check_eq("fast_w0_data", qc_data[0], 32'h01020304);
        check_eq("fast_w1_data", qc_data[1], 32'hA5B6C7D8);
        check_eq("fast_w2_addr", qc_addr[2], 2);
        check_eq("fast_w2_data", qc_data[2], 32'hFFFFFFFF);
        check_eq("fast_count", cnt_c, 3);
        check_eq("fast_sum", sum_c, SUM_C);

        check_eq("fl_we_n_always_high", we_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_boot.md
Name: mips_cpu_boot

Overview:
- Flash boot loader front-end of the mips_cpu system.
- After reset, it reads a program image from the byte-wide parallel flash, 4 bytes per 32-bit word, big-endian.
- Each assembled word goes through a request/acknowledge write port into main memory, which is served by the SDRAM (mt48lc4m16a2) controller.
- When all words are copied, it asserts boot_done to release the CPU core from reset.

Parameters:
- FLASH_WAIT, 4: clock cycles from an FL_ADDR change to FL_DQ sampling (flash access time at 50 MHz); legal range 1..15.
- BOOT_WORDS, 32768: number of 32-bit words to copy; legal range 1..2^20.
- FLASH_BASE, 0: byte address in flash of word 0; must be 4-byte aligned.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- Global_Reset  in  1  asynchronous, active-high reset.
- FL_ADDR  out  22  flash byte address.
- FL_DQ  in  8  flash read data; never driven by this block.
- FL_CE_N  out  1  flash chip enable, active low.
- FL_OE_N  out  1  flash output enable, active low.
- FL_WE_N  out  1  flash write enable; constant 1.
- FL_RST_N  out  1  flash reset, active low.
- mem_wr_req  out  1  memory write request.
- mem_wr_addr  out  20  memory word address.
- mem_wr_data  out  32  memory write data.
- mem_wr_ack  in  1  memory accepts the write on this edge.
- boot_count  out  20  number of words written so far.
- boot_done  out  1  copy complete; CPU may run.
- checksum  out  32  image checksum (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high), all outputs: FL_ADDR=0, FL_CE_N=1, FL_OE_N=1, FL_WE_N=1, FL_RST_N=0, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, boot_count=0, boot_done=0, checksum=0; state=WAKE.
- Asserting reset mid-operation aborts the copy immediately. After release the copy restarts from word 0.
- WAKE:
  - FL_RST_N=1 from the first clock after reset release.
  - Wait FLASH_WAIT cycles, then go to READ with word index w=0 and byte index b=0.
- READ:
  - FL_CE_N=0, FL_OE_N=0, FL_ADDR = FLASH_BASE + 4*w + b.
  - FL_DQ is sampled on the FLASH_WAIT-th rising edge after FL_ADDR takes its new value.
  - Byte placement: b=0 -> bits 31:24, b=1 -> 23:16, b=2 -> 15:8, b=3 -> 7:0.
  - After b=3 is sampled, go to WRITE. Otherwise increment b and update FL_ADDR on the same edge.
  - Cost: 4*FLASH_WAIT cycles per word.
- WRITE:
  - mem_wr_req=1, mem_wr_addr=w, mem_wr_data=assembled word; all three held stable until the transfer.
  - A transfer occurs on an edge where mem_wr_req=1 and mem_wr_ack=1.
  - On that edge: mem_wr_req drops, boot_count=w+1, and checksum updates.
  - Then, if w+1==BOOT_WORDS, go to DONE; otherwise w=w+1, b=0, go to READ.
  - mem_wr_ack while mem_wr_req=0 is ignored.
  - ack may be held high permanently; minimum occupancy is then 1 cycle per word.
- FL_CE_N and FL_OE_N stay 0 during WRITE. FL_ADDR holds the last byte address.
- DONE:
  - FL_CE_N=1, FL_OE_N=1, FL_ADDR=0, boot_done=1.
  - Terminal state until the next reset. boot_count=BOOT_WORDS; mem_wr_req=0.
- FL_ADDR wraps modulo 2^22 if FLASH_BASE + 4*BOOT_WORDS exceeds 4 MB.

Optional Feature:
- BOOT_CHECKSUM_EN defined:
  - checksum accumulates the 32-bit wrapping sum of every accepted mem_wr_data.
  - It updates on the transfer edge and holds its final value in DONE.
- Not defined: checksum is constant 0 and no adder is synthesised.

Test Plan:
- Basic copy:
  - Setup: FLASH_WAIT=4, BOOT_WORDS=2, FLASH_BASE=0; flash bytes 3C 1D 00 01 27 BD FF F0; ack tied high.
  - Required: writes (0, 0x3C1D0001) then (1, 0x27BDFFF0).
  - Required: first mem_wr_req rises 4 cycles (WAKE) plus 16 cycles after reset release.
  - Required: boot_done=1, boot_count=2, checksum=0x63DAFFF1 (with macro).
- Ack stall:
  - Setup: hold mem_wr_ack=0 for 10 cycles during the first WRITE.
  - Required: req, addr and data stay stable; exactly one write recorded per word; no flash address advance.
- Address sequence: FLASH_BASE=0x100, BOOT_WORDS=1 -> FL_ADDR steps 0x100, 0x101, 0x102, 0x103, each held FLASH_WAIT cycles.
- Mid-copy reset:
  - Setup: assert Global_Reset during the second word's READ.
  - Required: all outputs take reset values asynchronously; after release the copy restarts at word 0, with first write addr=0.
- Reset values and idle pins:
  - During reset: FL_RST_N=0, FL_WE_N=1, FL_CE_N=1.
  - Throughout: FL_WE_N=1 in every cycle.
  - In DONE: FL_CE_N=1 and FL_OE_N=1, and an ack pulse causes no write.
- FLASH_WAIT=1: a byte is sampled every cycle; BOOT_WORDS=3 completes in 1 + 12 + 3 cycles with ack high.
